// File: rtl/ps2_frame_receiver.sv
// PS/2 device-to-host frame receiver: deframes 11-bit frames on keyboard_clk falling edges and
// hands good bytes to the consumer through a one-entry valid/ready holding register.
module ps2_frame_receiver #(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int TIMER_WIDTH    = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       keyboard_clk,
  input  logic       keyboard_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       parity_error,
  output logic       frame_error,
  output logic       timeout,
  output logic       overrun,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t                 state_reg;
  logic                   prev_clk_reg;
  logic [7:0]             shift_reg;
  logic [2:0]             bit_cnt_reg;
  logic                   parity_bit_reg;
  logic [TIMER_WIDTH-1:0] timer_reg;
  logic [7:0]             rx_data_reg;
  logic                   rx_valid_reg;
  logic                   parity_error_reg;
  logic                   frame_error_reg;
  logic                   timeout_reg;
  logic                   overrun_reg;
  logic                   busy_reg;

  logic fall;
  logic timer_expired;
  logic parity_ok;

  assign fall          = prev_clk_reg && !keyboard_clk;
  assign timer_expired = (timer_reg == TIMER_WIDTH'(TIMEOUT_CYCLES - 1));
  // Odd parity: the eight data bits plus the parity bit must hold an odd number of ones.
  assign parity_ok     = ^{shift_reg, parity_bit_reg};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      prev_clk_reg     <= 1'b1;
      shift_reg        <= '0;
      bit_cnt_reg      <= '0;
      parity_bit_reg   <= 1'b0;
      timer_reg        <= '0;
      rx_data_reg      <= 8'h00;
      rx_valid_reg     <= 1'b0;
      parity_error_reg <= 1'b0;
      frame_error_reg  <= 1'b0;
      timeout_reg      <= 1'b0;
      overrun_reg      <= 1'b0;
      busy_reg         <= 1'b0;
    end else begin
      prev_clk_reg     <= keyboard_clk;
      parity_error_reg <= 1'b0;
      frame_error_reg  <= 1'b0;
      timeout_reg      <= 1'b0;
      overrun_reg      <= 1'b0;

      // A consumer handshake empties the holding register; a same-cycle good byte below refills it.
      if (rx_valid_reg && rx_ready) begin
        rx_valid_reg <= 1'b0;
      end

      if (state_reg == IDLE) begin
        timer_reg <= '0;
        if (fall && !keyboard_data) begin
          state_reg   <= DATA;
          bit_cnt_reg <= '0;
          busy_reg    <= 1'b1;
        end
      end else if (fall) begin
        timer_reg <= '0;
        case (state_reg)
          DATA: begin
            shift_reg   <= {keyboard_data, shift_reg[7:1]};
            bit_cnt_reg <= bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) begin
              state_reg <= PARITY;
            end
          end
          PARITY: begin
            parity_bit_reg <= keyboard_data;
            state_reg      <= STOP;
          end
          default: begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            if (!keyboard_data) begin
              frame_error_reg <= 1'b1;
            end else if (!parity_ok) begin
              parity_error_reg <= 1'b1;
            end else if (!rx_valid_reg || rx_ready) begin
              rx_data_reg  <= shift_reg;
              rx_valid_reg <= 1'b1;
            end else begin
              overrun_reg <= 1'b1;
            end
          end
        endcase
      end else if (timer_expired) begin
        timeout_reg <= 1'b1;
        timer_reg   <= '0;
        state_reg   <= IDLE;
        busy_reg    <= 1'b0;
      end else begin
        timer_reg <= timer_reg + 1'b1;
      end
    end
  end

  assign rx_data      = rx_data_reg;
  assign rx_valid     = rx_valid_reg;
  assign parity_error = parity_error_reg;
  assign frame_error  = frame_error_reg;
  assign timeout      = timeout_reg;
  assign overrun      = overrun_reg;
  assign busy         = busy_reg;

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Directed bench for ps2_frame_receiver: expected output events are queued as frames are sent
// and matched in order against the events observed on the DUT outputs.
module tb_ps2_frame_receiver;

  localparam int T = 40;

  localparam logic [3:0] EV_ACC   = 4'd1;
  localparam logic [3:0] EV_PERR  = 4'd2;
  localparam logic [3:0] EV_FERR  = 4'd3;
  localparam logic [3:0] EV_TOUT  = 4'd4;
  localparam logic [3:0] EV_OVR   = 4'd5;
  localparam logic [3:0] EV_MULTI = 4'd6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       keyboard_clk = 1'b1;
  logic       keyboard_data = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       parity_error;
  logic       frame_error;
  logic       timeout;
  logic       overrun;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;
  int valid_cnt = 0;
  int tout_at;
  logic busy_pre;

  logic [11:0] exp_q[$];
  logic [11:0] obs_q[$];

  ps2_frame_receiver #(.TIMEOUT_CYCLES(T), .TIMER_WIDTH(6)) dut (
    .clk(clk), .rst(rst), .keyboard_clk(keyboard_clk), .keyboard_data(keyboard_data),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .parity_error(parity_error), .frame_error(frame_error), .timeout(timeout),
    .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  // Advance one clock; record a handshake that the coming edge completes, then any pulse it produced.
  task automatic tick();
    int np;
    if (rx_valid === 1'b1 && rx_ready === 1'b1) obs_q.push_back({EV_ACC, rx_data});
    @(negedge clk);
    np = int'(parity_error) + int'(frame_error) + int'(timeout) + int'(overrun);
    if (rx_valid === 1'b1) valid_cnt++;
    if (np > 1)                obs_q.push_back({EV_MULTI, 8'h00});
    else if (parity_error)     obs_q.push_back({EV_PERR, 8'h00});
    else if (frame_error)      obs_q.push_back({EV_FERR, 8'h00});
    else if (timeout)          obs_q.push_back({EV_TOUT, 8'h00});
    else if (overrun)          obs_q.push_back({EV_OVR, 8'h00});
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
    $display("check %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  task automatic match_events(input string tag);
    logic [11:0] o;
    logic [11:0] e;
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hFFF;
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 12'hFFF;
      chk(tag, {20'h0, o}, {20'h0, e});
    end
  endtask

  task automatic send_bit(input logic b);
    keyboard_data = b;
    repeat (3) tick();
    keyboard_clk = 1'b0;
    repeat (3) tick();
    keyboard_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(stop);
    repeat (3) tick();
  endtask

  initial begin
    repeat (2) tick();
    rst = 1'b0;
    tick();
    chk("reset_rx_data", {24'h0, rx_data}, 32'h00);
    chk("reset_rx_valid", {31'h0, rx_valid}, 32'h0);
    chk("reset_busy", {31'h0, busy}, 32'h0);
    chk("reset_pulses", {28'h0, parity_error, frame_error, timeout, overrun}, 32'h0);

    // Good byte with the consumer ready: valid for exactly one cycle.
    rx_ready = 1'b1;
    valid_cnt = 0;
    exp_q.push_back({EV_ACC, 8'h1C});
    send_frame(8'h1C, ~^8'h1C, 1'b1);
    chk("good_1c_valid_cycles", valid_cnt, 1);
    chk("good_1c_busy", {31'h0, busy}, 32'h0);
    match_events("good_1c_events");

    valid_cnt = 0;
    exp_q.push_back({EV_PERR, 8'h00});
    send_frame(8'hF0, 1'b0, 1'b1);
    chk("perr_f0_valid_cycles", valid_cnt, 0);
    chk("perr_f0_busy", {31'h0, busy}, 32'h0);
    match_events("perr_f0_events");

    valid_cnt = 0;
    exp_q.push_back({EV_FERR, 8'h00});
    send_frame(8'hAA, 1'b1, 1'b0);
    chk("ferr_aa_valid_cycles", valid_cnt, 0);
    match_events("ferr_aa_events");

    // Abandoned frame: start plus three data bits, then the clock stays high.
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    keyboard_data = 1'b1;
    repeat (3) tick();
    keyboard_clk = 1'b0;
    tick();
    tout_at = 0;
    busy_pre = 1'b0;
    for (int i = 1; i <= T + 5; i++) begin
      if (i == 2) keyboard_clk = 1'b1;
      tick();
      if (i == T - 1) busy_pre = busy;
      if (timeout === 1'b1 && tout_at == 0) tout_at = i;
    end
    exp_q.push_back({EV_TOUT, 8'h00});
    chk("tout_cycles_after_fall", tout_at, T);
    chk("tout_busy_before", {31'h0, busy_pre}, 32'h1);
    chk("tout_busy_after", {31'h0, busy}, 32'h0);
    exp_q.push_back({EV_ACC, 8'h29});
    send_frame(8'h29, ~^8'h29, 1'b1);
    match_events("tout_then_29_events");

    // Consumer stalled: second good byte overruns, first is retained.
    rx_ready = 1'b0;
    send_frame(8'h12, ~^8'h12, 1'b1);
    exp_q.push_back({EV_OVR, 8'h00});
    send_frame(8'h59, ~^8'h59, 1'b1);
    chk("ovr_held_data", {24'h0, rx_data}, 32'h12);
    chk("ovr_held_valid", {31'h0, rx_valid}, 32'h1);
    exp_q.push_back({EV_ACC, 8'h12});
    rx_ready = 1'b1;
    repeat (2) tick();
    chk("ovr_drained_valid", {31'h0, rx_valid}, 32'h0);
    match_events("ovr_events");

    // Reset in the middle of a frame discards it silently.
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b0);
    chk("mid_frame_busy", {31'h0, busy}, 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_reset_outputs", {20'h0, rx_data, rx_valid, parity_error, frame_error, timeout},
        32'h0);
    chk("mid_reset_busy_overrun", {30'h0, busy, overrun}, 32'h0);
    exp_q.push_back({EV_ACC, 8'hE0});
    send_frame(8'hE0, ~^8'hE0, 1'b1);
    match_events("after_reset_e0_events");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ps2_frame_receiver.md
Name: ps2_frame_receiver

Overview:
- Consumes the conditioned keyboard_clk / keyboard_data pair from the keyboard signal conditioning stage.
- Deframes 11-bit PS/2 device-to-host frames: start bit 0, 8 data bits LSB first, odd parity bit, stop bit 1.
- Delivers each good byte through a one-entry valid/ready holding register to the scancode consumer.
- Reports parity, framing, timeout and overrun events as single-cycle pulses.

Parameters:
- TIMEOUT_CYCLES, 100000, number of clk cycles without a keyboard_clk falling edge, inside a frame, after which the frame is aborted (2 ms at 50 MHz).
- TIMER_WIDTH, 17, width of the inactivity counter; must satisfy 2^TIMER_WIDTH > TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- keyboard_clk  input  1  conditioned PS/2 clock, already synchronous to clk.
- keyboard_data  input  1  conditioned PS/2 data, already synchronous to clk.
- rx_data  output  8  received byte; valid while rx_valid = 1.
- rx_valid  output  1  holding register full.
- rx_ready  input  1  consumer accepts rx_data when rx_valid && rx_ready.
- parity_error  output  1  one-cycle pulse: frame dropped, bad parity.
- frame_error  output  1  one-cycle pulse: frame dropped, stop bit = 0.
- timeout  output  1  one-cycle pulse: frame aborted on inactivity.
- overrun  output  1  one-cycle pulse: good byte dropped because the holding register was full.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (rst = 1 at a clk edge) sets:
  - state = IDLE; prev_clk = 1; shift register, bit counter and timer = 0.
  - rx_data = 0x00; rx_valid, all error pulses and busy = 0.
  - Reset mid-frame discards the partial frame with no error pulse.
- Falling edge detect: fall = prev_clk && !keyboard_clk. prev_clk is registered every cycle. keyboard_data is sampled in the same cycle that fall is true.
- State machine, advancing only when fall = 1 unless noted:
  - IDLE: data = 0 -> DATA, bit_cnt = 0, timer = 0. data = 1 -> stay in IDLE silently (spurious edge).
  - DATA: shift the data bit into the MSB of the shift register (shift right) and increment bit_cnt. When the 8th bit is taken -> PARITY. After 8 bits the shift register holds the byte LSB-correct.
  - PARITY: capture the parity bit -> STOP.
  - STOP: capture the stop bit, evaluate the frame, then -> IDLE.
- Frame evaluation, checked in priority order:
  - stop = 0: frame_error pulse; byte dropped; parity not reported.
  - XOR of the 8 data bits and the parity bit = 0: parity_error pulse; byte dropped.
  - Otherwise: good byte.
- Latency: when fall for the stop bit is true in cycle N, the error pulse or the rx_valid/rx_data update is visible in cycle N+1.
- Holding register:
  - A good byte with rx_valid = 0 loads rx_data and sets rx_valid = 1.
  - rx_valid stays high and rx_data stays stable until a cycle with rx_ready = 1, after which rx_valid = 0 next cycle.
  - Good byte in the same cycle as rx_valid && rx_ready: the old byte is consumed, the new byte loads, and rx_valid stays 1.
  - Good byte while rx_valid && !rx_ready: overrun pulse; the new byte is dropped; the old byte is retained.
- Timeout:
  - In DATA, PARITY or STOP, the timer increments each cycle and clears on every fall.
  - When timer = TIMEOUT_CYCLES-1 with no fall: timeout pulse, -> IDLE, and the partial byte is discarded.
  - If fall and the timeout condition occur in the same cycle, fall wins.
  - The timer is held at 0 in IDLE.
- Pulse overlap: at most one of parity_error, frame_error, timeout and overrun is asserted in any cycle.
- busy: registered; equals (state != IDLE).

Test Plan:
- Frame 0x1C (bits LSB first 0,0,1,1,1,0,0,0; parity 0; stop 1), rx_ready = 1 -> rx_data = 0x1C, rx_valid high for exactly 1 cycle, no error pulses.
- Frame 0xF0 sent with parity 0 (correct value is 1) -> one parity_error pulse, rx_valid stays 0, busy = 0 afterwards.
- Frame 0xAA (correct parity 1) with stop bit 0 -> frame_error pulse only, no parity_error, no rx_valid.
- Send the start bit plus 3 data bits, then hold keyboard_clk high -> timeout pulse exactly TIMEOUT_CYCLES cycles after the last fall, busy drops. A following full 0x29 frame is received correctly.
- rx_ready = 0; send 0x12 then 0x59 -> rx_data = 0x12 held with rx_valid = 1; one overrun pulse at the end of the second frame. Then raise rx_ready -> 0x12 consumed, rx_valid = 0.
- Assert rst for 1 cycle after the 5th data bit of a frame -> all outputs 0 next cycle, no error pulse. The next complete 0xE0 frame is delivered as rx_data = 0xE0.
